uart_demo_mem_arbiter: RTL

Two-requester, round-robin Avalon-MM arbiter that shares the single-port 40000 x 32 on-chip memory between the Nios data master (m0) and the UART DMA engine (m1). It sits between both masters and the memory slave port. It accepts at most one transaction per cycle, routes it to the memory, and returns read data to the owning master with a `readdatavalid` pulse. Out-of-range accesses are absorbed and flagged.

---
 rtl/uart_demo_mem_pkg.sv | 13 +
 rtl/uart_demo_rr_arb2.sv | 33 +++
 rtl/uart_demo_mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_demo_mem_pkg.sv
// rtl/uart_demo_mem_pkg.sv - shared defaults and owner type for the memory arbiter
package uart_demo_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 40000;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

endpackage

// File: rtl/uart_demo_rr_arb2.sv
// rtl/uart_demo_rr_arb2.sv - two-way round-robin grant with last-grant memory
module uart_demo_rr_arb2
    import uart_demo_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    owner_e last_grant;

    // On a tie the master that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == OWN_M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWN_M1;
        end else if (accept) begin
            last_grant <= gnt[1] ? OWN_M1 : OWN_M0;
        end
    end

endmodule

// File: rtl/uart_demo_mem_arbiter.sv
// rtl/uart_demo_mem_arbiter.sv - shares the on-chip memory between Nios data master and UART DMA
module uart_demo_mem_arbiter
    import uart_demo_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                err_oob
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    logic              sel_m1;
    logic [ADDR_W-1:0] win_addr;
    logic [BE_W-1:0]   win_be;
    logic [DATA_W-1:0] win_wdata;
    logic              win_read;
    logic              win_write;
    logic              in_range;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_pend;
    logic              rd_oob;
    owner_e            rd_owner;
    logic              err_q;
    logic [DATA_W-1:0] ret_data;

    // Requests are masked during reset so every master sees waitrequest high.
    assign req = {m1_read | m1_write, m0_read | m0_write} & {2{reset_n}};

    uart_demo_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .accept  (accept),
        .gnt     (gnt)
    );

    assign accept    = |gnt;
    assign sel_m1    = gnt[1];
    assign win_addr  = sel_m1 ? m1_address    : m0_address;
    assign win_be    = sel_m1 ? m1_byteenable : m0_byteenable;
    assign win_wdata = sel_m1 ? m1_writedata  : m0_writedata;
    assign win_write = sel_m1 ? m1_write      : m0_write;
    assign win_read  = sel_m1 ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
    assign in_range  = {1'b0, win_addr} < DEPTH_L;

    assign m0_waitrequest = ~gnt[0];
    assign m1_waitrequest = ~gnt[1];

    assign mem_address    = accept ? win_addr  : addr_q;
    assign mem_byteenable = accept ? win_be    : be_q;
    assign mem_writedata  = accept ? win_wdata : wdata_q;
    assign mem_chipselect = accept & in_range;
    assign mem_write      = accept & in_range & win_write;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rd_pend  <= 1'b0;
            rd_oob   <= 1'b0;
            rd_owner <= OWN_M0;
            err_q    <= 1'b0;
        end else begin
            rd_pend <= accept & win_read;
            err_q   <= accept & ~in_range;
            if (accept) begin
                addr_q   <= win_addr;
                be_q     <= win_be;
                wdata_q  <= win_wdata;
                rd_oob   <= ~in_range;
                rd_owner <= sel_m1 ? OWN_M1 : OWN_M0;
            end
        end
    end

    // Memory output is unregistered, so the return is steered straight from it.
    assign ret_data         = rd_oob ? '0 : mem_readdata;
    assign m0_readdatavalid = rd_pend & (rd_owner == OWN_M0);
    assign m1_readdatavalid = rd_pend & (rd_owner == OWN_M1);
    assign m0_readdata      = m0_readdatavalid ? ret_data : '0;
    assign m1_readdata      = m1_readdatavalid ? ret_data : '0;
    assign err_oob          = err_q;

endmodule
